// File: rtl/uart_tx_param.sv
// UART transmit engine: start, DATA_W data bits LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-word input FIFO in front of the engine.
module uart_tx_param #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_ce,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_rdy,
    input  logic [1:0]        par_mode,
    input  logic              stop2,
    output logic              txd,
    output logic              tx_busy
);
    // state  | meaning
    // IDLE   | line high, waiting for a word
    // WCE    | word loaded, waiting for the first bit tick
    // START  | start bit on the line
    // DATA   | data bits, LSB first
    // PAR    | parity bit
    // STOP1  | first stop bit
    // STOP2  | second stop bit
    localparam int CNT_W = $clog2(DATA_W);

    if (DATA_W < 5 || DATA_W > 9 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("uart_tx_param: illegal DATA_W or FIFO_DEPTH");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_WCE, S_START, S_DATA, S_PAR, S_STOP1, S_STOP2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shifter;
    logic [CNT_W-1:0]  bit_cnt;
    logic              par_bit;
    logic [1:0]        mode_q;
    logic              stop2_q;
    logic              word_avail;
    logic [DATA_W-1:0] word;
    logic              load;
    logic              par_next;

    assign load = (state == S_IDLE) && word_avail;

`ifdef UART_TX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    count_next;
    logic              push;

    assign push       = tx_valid && tx_rdy;
    assign word_avail = (count != '0);
    assign word       = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !load)
            count_next = count + 1'b1;
        else if (load && !push)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            tx_rdy <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (load)
                rd_ptr <= rd_ptr + 1'b1;
            count  <= count_next;
            tx_rdy <= (count_next != (PTR_W+1)'(FIFO_DEPTH));
        end
    end
`else
    logic frame_end;

    assign word_avail = tx_valid && tx_rdy;
    assign word       = tx_data;
    assign frame_end  = bit_ce && (((state == S_STOP1) && !stop2_q) || (state == S_STOP2));

    // Without a FIFO the handshake cycle is the load cycle itself.
    always_ff @(posedge clk) begin
        if (rst)
            tx_rdy <= 1'b1;
        else if (load)
            tx_rdy <= 1'b0;
        else if (frame_end)
            tx_rdy <= 1'b1;
    end
`endif

    always_comb begin
        case (par_mode)
            2'b01:   par_next = ^word;
            2'b10:   par_next = ~^word;
            2'b11:   par_next = 1'b1;
            default: par_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            txd     <= 1'b1;
            tx_busy <= 1'b0;
            bit_cnt <= '0;
            shifter <= '0;
            par_bit <= 1'b0;
            mode_q  <= 2'b00;
            stop2_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (word_avail) begin
                        shifter <= word;
                        par_bit <= par_next;
                        mode_q  <= par_mode;
                        stop2_q <= stop2;
                        tx_busy <= 1'b1;
                        if (bit_ce) begin
                            txd   <= 1'b0;
                            state <= S_START;
                        end else begin
                            state <= S_WCE;
                        end
                    end
                end
                S_WCE: begin
                    if (bit_ce) begin
                        txd   <= 1'b0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (bit_ce) begin
                        txd     <= shifter[0];
                        shifter <= {1'b0, shifter[DATA_W-1:1]};
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_ce) begin
                        // bit_cnt counts data bits already completed on the line
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                            bit_cnt <= '0;
                            if (mode_q != 2'b00) begin
                                txd   <= par_bit;
                                state <= S_PAR;
                            end else begin
                                txd   <= 1'b1;
                                state <= S_STOP1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            txd     <= shifter[0];
                            shifter <= {1'b0, shifter[DATA_W-1:1]};
                        end
                    end
                end
                S_PAR: begin
                    if (bit_ce) begin
                        txd   <= 1'b1;
                        state <= S_STOP1;
                    end
                end
                S_STOP1: begin
                    if (bit_ce) begin
                        if (stop2_q) begin
                            state <= S_STOP2;
                        end else begin
                            state   <= S_IDLE;
                            tx_busy <= 1'b0;
                        end
                    end
                end
                S_STOP2: begin
                    if (bit_ce) begin
                        state   <= S_IDLE;
                        tx_busy <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
